// File: rtl/dma_bus_arbiter.sv
// Shares the CPU bus between the 6502 core, sprite OAM DMA and DMC sample fetch.
// Define DMA_STATS_EN to build the saturating stolen-cycle counter.
module dma_bus_arbiter #(
    parameter logic [15:0] OAM_PORT = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ce_i,
    input  logic [15:0]       cpu_aout_i,
    input  logic [7:0]        cpu_dout_i,
    input  logic              cpu_mr_i,
    input  logic              cpu_mw_i,
    output logic              cpu_ce_o,
    input  logic [7:0]        din_i,
    output logic [15:0]       aout_o,
    output logic [7:0]        dout_o,
    output logic              mr_o,
    output logic              mw_o,
    input  logic              dmc_req_i,
    input  logic [15:0]       dmc_addr_i,
    output logic              dmc_ack_o,
    output logic [7:0]        dmc_data_o,
    output logic              dma_active_o,
    output logic [STAT_W-1:0] stall_cycles_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StGet,
        StPut,
        StDmcPad
    } state_e;

    state_e      state_q, state_d, cur_state;
    logic        put_cycle_q;
    logic        oam_pending_q, oam_pending_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic        dmc_ack_q, dmc_ack_d;
    logic [7:0]  dmc_data_q, dmc_data_d;
    logic        halt_now;
    logic        trigger;
    logic        stall;

    // HALT is exactly the CPU read cycle that requests it, so it is decoded from IDLE
    // rather than registered; the read is discarded and repeated later.
    assign halt_now  = (state_q == StIdle) && (oam_pending_q || dmc_req_i) && cpu_mr_i;
    assign cur_state = halt_now ? StHalt : state_q;
    assign stall     = (cur_state != StIdle);
    assign trigger   = (state_q == StIdle) && cpu_mw_i && (cpu_aout_i == OAM_PORT);

    assign cpu_ce_o     = ce_i & ~stall;
    assign dma_active_o = stall;
    assign dmc_ack_o    = dmc_ack_q;
    assign dmc_data_o   = dmc_data_q;

    always_comb begin
        state_d       = state_q;
        oam_pending_d = oam_pending_q;
        page_d        = page_q;
        idx_d         = idx_q;
        latch_d       = latch_q;
        dmc_ack_d     = 1'b0;
        dmc_data_d    = dmc_data_q;
        aout_o        = cpu_aout_i;
        dout_o        = cpu_dout_i;
        mr_o          = cpu_mr_i;
        mw_o          = cpu_mw_i;

        if (trigger) begin
            page_d        = cpu_dout_i;
            oam_pending_d = 1'b1;
        end

        case (cur_state)
            StIdle: begin
            end
            StHalt: begin
                state_d = put_cycle_q ? StGet : StAlign;
            end
            StAlign: begin
                mr_o    = 1'b0;
                mw_o    = 1'b0;
                state_d = StGet;
            end
            StGet: begin
                mr_o = 1'b1;
                mw_o = 1'b0;
                if (dmc_req_i) begin
                    aout_o     = dmc_addr_i;
                    dmc_data_d = din_i;
                    dmc_ack_d  = 1'b1;
                    state_d    = oam_pending_q ? StDmcPad : StIdle;
                end else if (oam_pending_q) begin
                    aout_o  = {page_q, idx_q};
                    latch_d = din_i;
                    state_d = StPut;
                end else begin
                    state_d = StIdle;
                end
            end
            StPut: begin
                aout_o = OAM_DATA;
                dout_o = latch_q;
                mr_o   = 1'b0;
                mw_o   = 1'b1;
                idx_d  = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    oam_pending_d = 1'b0;
                    state_d       = StIdle;
                end else begin
                    state_d = StGet;
                end
            end
            StDmcPad: begin
                mr_o    = 1'b0;
                mw_o    = 1'b0;
                state_d = StGet;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            put_cycle_q   <= 1'b0;
            oam_pending_q <= 1'b0;
            page_q        <= 8'h00;
            idx_q         <= 8'h00;
            latch_q       <= 8'h00;
            dmc_ack_q     <= 1'b0;
            dmc_data_q    <= 8'h00;
        end else if (ce_i) begin
            state_q       <= state_d;
            put_cycle_q   <= ~put_cycle_q;
            oam_pending_q <= oam_pending_d;
            page_q        <= page_d;
            idx_q         <= idx_d;
            latch_q       <= latch_d;
            dmc_ack_q     <= dmc_ack_d;
            dmc_data_q    <= dmc_data_d;
        end
    end

`ifdef DMA_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (ce_i && stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares the CPU bus between the 6502 core and two DMA masters: sprite OAM DMA, triggered by a CPU write to $4014, and APU DMC sample fetch.
- Sits between the CPU core's bus outputs and the system bus.
- Steals cycles by gating the CPU clock enable, drives the bus itself while DMA is active, and sequences halt, alignment and get/put cycles.

Parameters:
- OAM_PORT, 16'h4014, CPU write address that triggers OAM DMA (data byte = source page).
- OAM_DATA, 16'h2004, destination address for each OAM put write.
- STAT_W, 16, width of the stolen-cycle counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  CPU cycle enable from clock divider; all state advances only when ce=1
- cpu_aout  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_mr  in  1  CPU read strobe
- cpu_mw  in  1  CPU write strobe
- cpu_ce  out  1  gated enable to CPU core; = ce & ~stall
- din  in  8  system bus read data
- aout  out  16  system bus address
- dout  out  8  system bus write data
- mr  out  1  system bus read strobe
- mw  out  1  system bus write strobe
- dmc_req  in  1  DMC fetch request (level; held until ack)
- dmc_addr  in  16  DMC fetch address
- dmc_ack  out  1  one-ce pulse; dmc_data valid in the same cycle
- dmc_data  out  8  registered copy of din from the DMC read
- dma_active  out  1  high while any non-IDLE state is held
- stall_cycles  out  STAT_W  stolen-cycle count (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE, put_cycle=0, oam_pending=0, page=0, idx=0, latch=0, dmc_ack=0, dmc_data=0, dma_active=0, stall_cycles=0.
- put_cycle toggles on every ce. A cycle with put_cycle=0 is a get cycle; put_cycle=1 is a put cycle.
- Trigger: on ce with cpu_mw=1 and cpu_aout==OAM_PORT, set page<=cpu_dout and oam_pending<=1. The CPU write itself passes through. A retrigger while OAM DMA is running is ignored.
- Bus mux: in IDLE, and in HALT, bus = CPU signals. Otherwise the arbiter drives the bus and stall=1.
- States, evaluated on ce:
  - IDLE: if (oam_pending | dmc_req) & cpu_mr, go to HALT. stall=1 in this cycle, so the CPU repeats its read later. CPU writes are never halted: wait for the next read.
  - HALT: one cycle; CPU address is presented and the read is discarded. Next: ALIGN if the next cycle is a put cycle, else GET.
  - ALIGN: dummy cycle; bus idle (mr=mw=0). Next: GET.
  - GET (get cycle): if dmc_req, read dmc_addr, capture dmc_data<=din, pulse dmc_ack, go to DMC_PAD if oam_pending else IDLE. Else read {page,idx}, latch<=din, go to PUT.
  - PUT: write latch to OAM_DATA, idx<=idx+1. If idx was 8'hFF: clear oam_pending, idx<=0, go to IDLE. Else go to GET.
  - DMC_PAD: dummy put cycle after a DMC steal inside OAM DMA. Next: GET.
- DMC has priority over OAM on every get cycle. OAM costs 513 cycles (halt on put) or 514 (halt on get); each DMC steal adds 2.
- dmc_req is sampled only in GET; the requester must drop it on dmc_ack.
- cpu_ce is low during HALT, ALIGN, GET, PUT and DMC_PAD, and high in IDLE whenever ce=1.
- reset asserted mid-DMA aborts immediately; bus returns to the CPU path.
- idx is 8-bit and wraps only at completion. Address = {page, idx} with no carry into page.

Optional Feature:
- DMA_STATS_EN defined: stall_cycles increments (saturating at all-ones) on every ce with stall=1. Cleared only by reset.
- Undefined: stall_cycles is constant 0 and no counter is built.

Test Plan:
- CPU writes $4014=$02, next read lands on a put cycle -> cpu_ce held low exactly 513 ce's; 256 reads $0200-$02FF, each followed by a write to $2004 of the same byte; dma_active falls after the $02FF put.
- Same trigger with the halt on a get cycle -> 514 stolen cycles; one ALIGN cycle with mr=mw=0.
- dmc_req with dmc_addr=$C123 while IDLE, din=$5A -> HALT, first GET reads $C123, dmc_ack pulses once with dmc_data=$5A, CPU resumes.
- dmc_req asserted mid-OAM at idx=$40 -> next GET reads the DMC address, then DMC_PAD, then $xx40 is read; total 515/516 cycles; OAM data is intact.
- Trigger followed by two CPU writes (stack push) -> no halt until the first cpu_mr cycle; both writes appear on the bus.
- reset asserted at idx=$80 -> all outputs return to reset values at once; cpu_ce follows ce; with DMA_STATS_EN, stall_cycles=0.
